rv_shm_mp: RTL
==============

Name: rv_shm_mp

Overview:
- Multi-port, multi-bank shared word memory for the rv32 subsystem.
- Lets NUM_PORT requesters (cores, DMA, host bridge) share one memory through per-bank round-robin arbitration and a req/gnt handshake.
- Each bank is a single-port, byte-write, read-first BRAM.
- Requests to different banks proceed in the same cycle; conflicting requests to the same bank are serialised.

Parameters:
- NUM_PORT, 4, number of requester ports (2..8).
- NUM_BANK, 4, number of banks; power of two, 1..8. Bank is selected by the low address bits.
- NUM_COL, 4, byte lanes per word.
- COL_WIDTH, 8, bits per lane.
- ADDR_WIDTH, 10, word-address width. Total depth is 2**ADDR_WIDTH words.
- DATA_WIDTH, NUM_COL*COL_WIDTH, word width (derived).

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- xreset  in  1  asynchronous, active-low reset.
- req  in  NUM_PORT  per-port access request.
- we  in  NUM_PORT*NUM_COL  per-port byte write enables. Port p uses slice [p*NUM_COL +: NUM_COL]. All zero means a read.
- addr  in  NUM_PORT*ADDR_WIDTH  per-port word address (slice p).
- wdata  in  NUM_PORT*DATA_WIDTH  per-port write data (slice p).
- gnt  out  NUM_PORT  combinational grant; the access is performed at this edge.
- rvalid  out  NUM_PORT  registered; high one cycle after a granted read.
- rdata  out  NUM_PORT*DATA_WIDTH  registered read data (slice p), valid while rvalid[p].

Behaviour:
- Address split:
  - bank = addr[BB-1:0], row = addr[ADDR_WIDTH-1:BB], where BB = log2(NUM_BANK).
  - NUM_BANK=1 gives BB=0: whole address is the row, single arbiter.
- Handshake:
  - Requester holds req, we, addr and wdata stable until it sees gnt high at a rising edge.
  - The access occurs at that edge.
  - Requester may drop req or present a new request in the following cycle.
  - gnt[p] is never high without req[p].
- Arbitration, per bank b:
  - Candidates are ports with req high and bank equal to b.
  - Round-robin pointer rr[b] is reset to 0.
  - Grant goes to the first candidate at or after rr[b], searching upward and wrapping modulo NUM_PORT.
  - On a grant to port p, rr[b] <= (p+1) mod NUM_PORT. No grant leaves rr[b] unchanged.
  - At most one grant per bank per cycle. Ports targeting different banks may all be granted in the same cycle.
- Write:
  - For each lane i with we[p][i]=1, that lane of bank[row] is replaced by wdata lane i at the grant edge.
  - Other lanes are unchanged.
  - No rvalid is produced for a write.
- Read:
  - A granted access with all-zero we is a read.
  - rdata[p] <= bank[row] at the grant edge.
  - rvalid[p] <= 1 for exactly one cycle.
  - Read latency: 1 cycle from the grant edge.
- Mixed lanes: a granted access with nonzero we is a write only (no rvalid).
- Read-first: rdata returns the old word if the same row was written at that edge. Only possible across back-to-back cycles; same-bank same-cycle conflicts cannot occur.
- Back-to-back: a port granted every cycle gets rvalid every cycle (full throughput, no bubbles).
- rdata[p] holds its last value while rvalid[p] is low.
- Reset (xreset low, async):
  - rvalid = 0, rdata = 0, all rr[b] = 0.
  - gnt is forced to 0 while in reset.
  - RAM contents are not reset.
  - Reset asserted mid-operation drops pending reads: no rvalid after release. Writes at edges before reset are retained.
- Deassertion of xreset is synchronised by the system; the first edge after release is a valid arbitration edge.
- No combinational path from rdata to gnt. gnt depends only on req, addr and rr.

Test Plan:
- After reset (NUM_PORT=4, NUM_BANK=4): port0 writes addr 0x005, we=4'hF, data 0xDEADBEEF; then reads addr 0x005 → gnt[0] both cycles, rvalid[0] exactly one cycle after the read grant, rdata[0]=0xDEADBEEF.
- Byte-enable: 0x11223344 stored at 0x010, then write we=4'b0101, data 0xAABBCCDD, then read → 0x11BB33DD.
- Conflict: ports 0–3 all hold reads to bank 1 (addrs 0x001, 0x005, 0x009, 0x00D) with rr=0 → grants in order p0,p1,p2,p3 on consecutive cycles; rvalid follows each by one cycle; pointer wraps to 0.
- Parallel: ports 0–3 read addrs 0x000, 0x001, 0x002, 0x003 (distinct banks) in one cycle → all four gnt high together; all four rvalid high next cycle.
- Fairness: port 2 holds req to bank 0 continuously while port 0 re-requests bank 0 each cycle → grants alternate p0,p2,p0,p2; neither port waits more than NUM_PORT-1 cycles.
- Reset mid-read: xreset asserted in the cycle after a read grant, before the next edge → rvalid stays 0, rdata=0; a prior write to 0x020 still reads back correctly after release.

Source files
------------

// File: rtl/rv_shm_mp.sv
// rv_shm_mp: multi-port shared word memory built from NUM_BANK interleaved byte-write banks.
// Each bank has its own round-robin arbiter; reads return one cycle after the grant edge.
module rv_shm_mp #(
  parameter int NUM_PORT   = 4,
  parameter int NUM_BANK   = 4,
  parameter int NUM_COL    = 4,
  parameter int COL_WIDTH  = 8,
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = NUM_COL * COL_WIDTH
) (
  input  logic                           clk,
  input  logic                           xreset,
  input  logic [NUM_PORT-1:0]            req,
  input  logic [NUM_PORT*NUM_COL-1:0]    we,
  input  logic [NUM_PORT*ADDR_WIDTH-1:0] addr,
  input  logic [NUM_PORT*DATA_WIDTH-1:0] wdata,
  output logic [NUM_PORT-1:0]            gnt,
  output logic [NUM_PORT-1:0]            rvalid,
  output logic [NUM_PORT*DATA_WIDTH-1:0] rdata
);

  localparam int BB    = $clog2(NUM_BANK);
  localparam int BK_W  = (BB == 0) ? 1 : BB;
  localparam int ROW_W = ADDR_WIDTH - BB;
  localparam int DEPTH = 2 ** ROW_W;
  localparam int PW    = $clog2(NUM_PORT);
  localparam logic [ADDR_WIDTH-1:0] BANK_MASK = ADDR_WIDTH'(NUM_BANK - 1);

  logic [BK_W-1:0]       w_port_bank  [NUM_PORT];
  logic [ROW_W-1:0]      w_port_row   [NUM_PORT];
  logic [NUM_COL-1:0]    w_port_we    [NUM_PORT];
  logic [DATA_WIDTH-1:0] w_port_wdata [NUM_PORT];
  logic [NUM_PORT-1:0]   w_gnt;

  logic [NUM_BANK-1:0]   w_bank_vld;
  logic [ROW_W-1:0]      w_bank_row   [NUM_BANK];
  logic [NUM_COL-1:0]    w_bank_we    [NUM_BANK];
  logic [DATA_WIDTH-1:0] w_bank_wdata [NUM_BANK];
  logic [DATA_WIDTH-1:0] w_bank_rd    [NUM_BANK];
  logic [PW-1:0]         w_rr_nxt     [NUM_BANK];

  logic [PW-1:0]         r_rr [NUM_BANK];
  logic [DATA_WIDTH-1:0] r_mem [NUM_BANK][DEPTH];
  logic [NUM_PORT-1:0]   r_rvalid;
  logic [NUM_PORT*DATA_WIDTH-1:0] r_rdata;

  // Split each port's address into bank (low bits) and row, and slice its write fields
  always_comb begin
    for (int p = 0; p < NUM_PORT; p++) begin
      w_port_bank[p]  = BK_W'(addr[p*ADDR_WIDTH +: ADDR_WIDTH] & BANK_MASK);
      w_port_row[p]   = ROW_W'(addr[p*ADDR_WIDTH +: ADDR_WIDTH] >> BB);
      w_port_we[p]    = we[p*NUM_COL +: NUM_COL];
      w_port_wdata[p] = wdata[p*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Per-bank round-robin pick: first requester at or after rr[b], wrapping; gnt held low in reset
  always_comb begin
    int idx;
    idx        = 0;
    w_gnt      = '0;
    w_bank_vld = '0;
    for (int b = 0; b < NUM_BANK; b++) begin
      w_bank_row[b]   = '0;
      w_bank_we[b]    = '0;
      w_bank_wdata[b] = '0;
      w_rr_nxt[b]     = r_rr[b];
      for (int k = 0; k < NUM_PORT; k++) begin
        idx = (int'(r_rr[b]) + k) % NUM_PORT;
        if (xreset && !w_bank_vld[b] && req[idx] && (w_port_bank[idx] == BK_W'(b))) begin
          w_bank_vld[b]   = 1'b1;
          w_gnt[idx]      = 1'b1;
          w_bank_row[b]   = w_port_row[idx];
          w_bank_we[b]    = w_port_we[idx];
          w_bank_wdata[b] = w_port_wdata[idx];
          w_rr_nxt[b]     = PW'((idx + 1) % NUM_PORT);
        end else begin
          w_bank_vld[b]   = w_bank_vld[b];
        end
      end
    end
  end

  // Asynchronous read port of each bank; sampled at the grant edge, so the old word is returned
  always_comb begin
    for (int b = 0; b < NUM_BANK; b++) begin
      w_bank_rd[b] = r_mem[b][w_bank_row[b]];
    end
  end

  // Byte-lane writes into the bank arrays (contents survive reset)
  always_ff @(posedge clk) begin
    for (int b = 0; b < NUM_BANK; b++) begin
      for (int c = 0; c < NUM_COL; c++) begin
        if (w_bank_vld[b] && w_bank_we[b][c]) begin
          r_mem[b][w_bank_row[b]][c*COL_WIDTH +: COL_WIDTH] <= w_bank_wdata[b][c*COL_WIDTH +: COL_WIDTH];
        end
      end
    end
  end

  // Round-robin pointers advance past the granted port only
  always_ff @(posedge clk or negedge xreset) begin
    if (!xreset) begin
      for (int b = 0; b < NUM_BANK; b++) begin
        r_rr[b] <= '0;
      end
    end else begin
      for (int b = 0; b < NUM_BANK; b++) begin
        r_rr[b] <= w_rr_nxt[b];
      end
    end
  end

  // Read response registers: one-cycle rvalid pulse, rdata held between reads
  always_ff @(posedge clk or negedge xreset) begin
    if (!xreset) begin
      r_rvalid <= '0;
      r_rdata  <= '0;
    end else begin
      for (int p = 0; p < NUM_PORT; p++) begin
        if (w_gnt[p] && (w_port_we[p] == '0)) begin
          r_rvalid[p] <= 1'b1;
          r_rdata[p*DATA_WIDTH +: DATA_WIDTH] <= w_bank_rd[w_port_bank[p]];
        end else begin
          r_rvalid[p] <= 1'b0;
        end
      end
    end
  end

  assign gnt    = w_gnt;
  assign rvalid = r_rvalid;
  assign rdata  = r_rdata;

endmodule
